// File: rtl/utmi_tx_replay.sv
// utmi_tx_replay: streams a packet image from sample RAM (Wishbone read master)
// onto the UTMI transmit interface, controlled via a small register slave.
// Optional build macro UTMI_TX_REPLAY_IRQ_EN adds irq_o and the IRQ_EN register (0x10).
module utmi_tx_replay #(
  parameter int BUF_WORDS = 2,
  parameter int LEN_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  input  logic        mem_stall_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        utmi_txvalid_o,
  output logic [7:0]  utmi_data_o,
  input  logic        utmi_txready_i
`ifdef UTMI_TX_REPLAY_IRQ_EN
  ,
  output logic        irq_o
`endif
);
  localparam int AW = $clog2(BUF_WORDS);
  localparam int CW = AW + 1;
  localparam int FW = LEN_W - 1;

  typedef enum logic [1:0] {IDLE, FILL, TX, DRAIN} state_e;
  state_e state_q, state_d;

  logic [31:0]      base_q, addr_q, rdata_q;
  logic [LEN_W-1:0] len_q, left_q;
  logic [FW-1:0]    fetch_q, words;
  logic [CW-1:0]    out_q, cnt_q;
  logic [CW:0]      inflight;
  logic [AW-1:0]    wp_q, rp_q;
  logic [1:0]       bidx_q;
  logic [31:0]      buf_q [BUF_WORDS];
  logic [31:0]      head_w;
  logic done_q, under_q, abrt_q, start_pend_q, ack_q;
  logic req, wr, busy, start, abort, start_acc;
  logic issue, ack_ok, push, tx_acc, last, fill_done;
  logic launch, zero_done, done_ev, under_ev, abort_ev, pop, flush;
`ifdef UTMI_TX_REPLAY_IRQ_EN
  logic irq_en_q;
  assign irq_o = irq_en_q & (done_q | under_q | abrt_q);
`endif

  assign req       = cyc_i & stb_i;
  assign wr        = req & we_i;
  assign busy      = (state_q == FILL) || (state_q == TX);
  assign start     = wr && (addr_i == 8'h00) && data_i[0];
  assign abort     = wr && (addr_i == 8'h00) && data_i[1] && busy;
  assign start_acc = start & ~busy;
  assign words     = FW'(({1'b0, len_q} + (LEN_W+1)'(3)) >> 2);

  // Prefetch as long as buffered + outstanding words leave room in the buffer.
  assign inflight   = {1'b0, cnt_q} + {1'b0, out_q};
  assign mem_stb_o  = busy && (fetch_q != '0) && (inflight < (CW+1)'(BUF_WORDS));
  assign issue      = mem_stb_o & ~mem_stall_i;
  assign mem_cyc_o  = mem_stb_o || (out_q != '0);
  assign mem_addr_o = addr_q;
  assign mem_sel_o  = 4'hF;
  assign mem_we_o   = 1'b0;
  assign ack_ok     = mem_ack_i && (out_q != '0);
  assign push       = ack_ok && busy;

  assign utmi_txvalid_o = (state_q == TX);
  assign head_w         = buf_q[rp_q];
  assign utmi_data_o    = utmi_txvalid_o ? head_w[{bidx_q, 3'b000} +: 8] : 8'h00;
  assign tx_acc         = utmi_txvalid_o & utmi_txready_i;
  assign last           = (left_q == LEN_W'(1));
  assign fill_done      = (cnt_q == CW'(BUF_WORDS)) || ((fetch_q == '0) && (out_q == '0));
  assign flush          = busy && (state_d == DRAIN);
  assign data_o         = rdata_q;
  assign ack_o          = ack_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle events; a final byte beats a same-cycle abort.
  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    zero_done = 1'b0;
    done_ev   = 1'b0;
    under_ev  = 1'b0;
    abort_ev  = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: if (start_acc || start_pend_q) begin
        if (len_q == '0) zero_done = 1'b1;
        else begin launch = 1'b1; state_d = FILL; end
      end
      FILL: if (abort) begin abort_ev = 1'b1; state_d = DRAIN; end
            else if (fill_done) state_d = TX;
      TX: if (tx_acc && last) begin done_ev = 1'b1; state_d = DRAIN; end
          else if (abort) begin abort_ev = 1'b1; state_d = DRAIN; end
          else if (tx_acc && bidx_q == 2'd3) begin
            pop = 1'b1;
            if (cnt_q < CW'(2)) begin under_ev = 1'b1; state_d = DRAIN; end
          end
      DRAIN: if (out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Config registers, sticky status and deferred start (START arriving while draining).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0; len_q <= '0; done_q <= 1'b0; under_q <= 1'b0; abrt_q <= 1'b0;
      start_pend_q <= 1'b0;
`ifdef UTMI_TX_REPLAY_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      if (wr && !busy && addr_i == 8'h04) base_q <= {data_i[31:2], 2'b00};
      if (wr && !busy && addr_i == 8'h08) len_q <= data_i[LEN_W-1:0];
      if (start_acc) begin done_q <= 1'b0; under_q <= 1'b0; abrt_q <= 1'b0; end
`ifdef UTMI_TX_REPLAY_IRQ_EN
      if (wr && addr_i == 8'h0C && data_i[0]) begin
        done_q <= 1'b0; under_q <= 1'b0; abrt_q <= 1'b0;
      end
      if (wr && addr_i == 8'h10) irq_en_q <= data_i[0];
`endif
      if (done_ev || zero_done) done_q <= 1'b1;
      if (under_ev) under_q <= 1'b1;
      if (abort_ev) abrt_q <= 1'b1;
      if (start_acc && state_q == DRAIN) start_pend_q <= 1'b1;
      else if (state_q == IDLE)          start_pend_q <= 1'b0;
    end
  end

  // Slave response: ack and read data one cycle after each request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0; rdata_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        case (addr_i)
          8'h04:   rdata_q <= base_q;
          8'h08:   rdata_q <= 32'(len_q);
          8'h0C:   rdata_q <= {28'd0, abrt_q, under_q, done_q, busy};
`ifdef UTMI_TX_REPLAY_IRQ_EN
          8'h10:   rdata_q <= {31'd0, irq_en_q};
`endif
          default: rdata_q <= '0;
        endcase
      end
    end
  end

  // Read address, words left to fetch, and outstanding read count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0; fetch_q <= '0; out_q <= '0;
    end else begin
      if (launch) begin addr_q <= base_q; fetch_q <= words; end
      else if (issue) begin addr_q <= addr_q + 32'd4; fetch_q <= fetch_q - 1'b1; end
      out_q <= out_q + CW'(issue) - CW'(ack_ok);
    end
  end

  // Prefetch FIFO; emptied on leaving the active states so late acks are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
      for (int i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
    end else if (flush || launch) begin
      wp_q <= '0; rp_q <= '0; cnt_q <= '0;
    end else begin
      if (push) begin buf_q[wp_q] <= mem_data_i; wp_q <= wp_q + 1'b1; end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Byte position within the head word and bytes left to send.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      left_q <= '0; bidx_q <= '0;
    end else if (launch) begin
      left_q <= len_q; bidx_q <= '0;
    end else if (tx_acc) begin
      left_q <= left_q - 1'b1; bidx_q <= bidx_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_utmi_tx_replay.sv
// Scoreboard bench for utmi_tx_replay: a RAM/Wishbone slave model and a UTMI sink
// run as independent processes; expected bytes and read addresses come from the
// bench RAM image and packet parameters.
module tb_utmi_tx_replay;
  logic        clk_i = 0, rst_ni = 0;
  logic [7:0]  addr_i = 0;
  logic [31:0] data_i = 0, data_o;
  logic        cyc_i = 0, stb_i = 0, we_i = 0, ack_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o, mem_cyc_o, mem_stb_o;
  logic        mem_stall_i = 0, mem_ack_i = 0;
  logic [31:0] mem_data_i = 0;
  logic        utmi_txvalid_o, utmi_txready_i = 0;
  logic [7:0]  utmi_data_o;

  always #8 clk_i = ~clk_i;

  utmi_tx_replay dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o),
    .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_stall_i(mem_stall_i),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .utmi_txvalid_o(utmi_txvalid_o), .utmi_data_o(utmi_data_o), .utmi_txready_i(utmi_txready_i)
  );

  typedef struct { int due; logic [31:0] d; } rsp_t;

  int          n_vec = 0, n_err = 0;
  logic [31:0] ram [256];
  logic [7:0]  exp_q [$];
  rsp_t        pend_q [$];
  int          stall_pct = 0, dly_min = 0, dly_max = 0, tx_mode = 0;
  int          tx_cnt = 0, rd_cnt = 0, cyc_n = 0;
  logic [31:0] exp_addr = 0;
  bit          saw_tx = 0, saw_cyc = 0, hold = 0, tog = 0, rdy = 0;
  logic [7:0]  hold_d = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wishbone RAM slave: pipelined, random stall, ack delay in [dly_min, dly_max].
  initial begin
    forever begin
      @(posedge clk_i); #1;
      cyc_n++;
      if (!rst_ni) begin
        pend_q.delete(); mem_ack_i = 0; mem_stall_i = 0;
        continue;
      end
      if (mem_cyc_o) saw_cyc = 1;
      mem_ack_i = 0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc_n + 1) begin
        mem_ack_i = 1; mem_data_i = pend_q[0].d; void'(pend_q.pop_front());
      end
      mem_stall_i = ($urandom_range(99, 0) < stall_pct);
      if (mem_stb_o && !mem_stall_i) begin
        chk("rd_addr", mem_addr_o, exp_addr);
        chk("rd_sel_we", {27'd0, mem_we_o, mem_sel_o}, 32'h0F);
        pend_q.push_back('{cyc_n + 2 + int'($urandom_range(dly_max, dly_min)), ram[exp_addr[9:2]]});
        exp_addr += 4;
        rd_cnt++;
      end
    end
  end

  // UTMI sink: drives txready per tx_mode and pops the expected byte on each transfer.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin hold = 0; utmi_txready_i = 0; continue; end
      if (utmi_txvalid_o) saw_tx = 1;
      if (hold && utmi_txvalid_o) chk("tx_hold", {24'd0, utmi_data_o}, {24'd0, hold_d});
      tog = ~tog;
      case (tx_mode)
        0:       rdy = 1;
        1:       rdy = tog;
        default: rdy = ($urandom_range(1, 0) == 1);
      endcase
      utmi_txready_i = rdy;
      hold   = utmi_txvalid_o && !rdy;
      hold_d = utmi_data_o;
      if (utmi_txvalid_o && rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_extra: got byte %h expected none", utmi_data_o);
        end else chk("tx_byte", {24'd0, utmi_data_o}, {24'd0, exp_q.pop_front()});
        tx_cnt++;
      end
    end
  end

  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] d, output logic [31:0] r);
    @(posedge clk_i); #1;
    addr_i = a; we_i = w; data_i = d; cyc_i = 1; stb_i = 1;
    @(posedge clk_i); #1;
    cyc_i = 0; stb_i = 0; we_i = 0;
    chk("slv_ack", {31'd0, ack_o}, 32'd1);
    r = data_o;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, d, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus(a, 1'b0, 32'd0, r);
  endtask

  // mode: 0 must complete, 1 complete or underrun, 2 must underrun, 3 abort after 10 bytes.
  task automatic run(input logic [31:0] base, input int len, input int mode);
    logic [31:0] st, wd, r;
    bit ok;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      wd = ram[8'((base >> 2) + 32'(i / 4))];
      exp_q.push_back(wd[8 * (i % 4) +: 8]);
    end
    wr(8'h04, base); wr(8'h08, 32'(len));
    tx_cnt = 0; rd_cnt = 0; exp_addr = base; saw_tx = 0; saw_cyc = 0;
    wr(8'h00, 32'h1);
    if (mode == 3) begin
      wr(8'h04, 32'h300);
      rd(8'h04, r);
      chk("base_locked", r, base);
      for (int k = 0; k < 5000 && tx_cnt < 10; k++) @(posedge clk_i);
      #1;
      wr(8'h00, 32'h2);
      chk("abort_txv", {31'd0, utmi_txvalid_o}, 32'd0);
    end
    ok = 0;
    for (int k = 0; k < 600; k++) begin
      rd(8'h0C, st);
      if (!st[0] && !mem_cyc_o) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL poll_timeout: status %h expected idle", st);
    end
    rd(8'h0C, st);
    if (mode == 3) chk("st_abort", st, 32'h8);
    else if (mode == 2 || (mode == 1 && st[2])) begin
      chk("st_under", st & 32'hD, 32'h4);
      chk("under_short", {31'd0, tx_cnt < len}, 32'd1);
    end else begin
      chk("st_done", st, 32'h2);
      chk("tx_count", tx_cnt, len);
      chk("rd_count", rd_cnt, (len + 3) / 4);
    end
    if (len == 0) chk("len0_quiet", {30'd0, saw_tx, saw_cyc}, 32'd0);
    chk("no_stray", pend_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    ram[8'h40] = 32'h44332211;
    ram[8'h41] = 32'h00000055;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_outs", {19'd0, ack_o, mem_cyc_o, mem_stb_o, mem_we_o, utmi_txvalid_o, utmi_data_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    rst_ni = 1;
    rd(8'h0C, r); chk("rst_status", r, 32'd0);
    rd(8'h04, r); chk("rst_base", r, 32'd0);
    rd(8'h08, r); chk("rst_len", r, 32'd0);
    wr(8'h04, 32'h0000_0103);
    rd(8'h04, r); chk("base_align", r, 32'h100);
    rd(8'h00, r); chk("ctrl_rd0", r, 32'd0);
    rd(8'h10, r); chk("irqen_absent", r, 32'd0);

    tx_mode = 0; run(32'h100, 5, 0);
    tx_mode = 1; run(32'h100, 5, 0);
    tx_mode = 0; run(32'h100, 0, 0);
    dly_min = 6; dly_max = 6; run(32'h0, 64, 2);
    dly_min = 0; dly_max = 0; run(32'h0, 256, 3);
    run(32'h20, 4, 0);

    for (int it = 0; it < 8; it++) begin
      tx_mode   = $urandom_range(2, 0);
      dly_max   = $urandom_range(1, 0);
      stall_pct = $urandom_range(30, 0);
      run(32'($urandom_range(255, 0)) * 4, $urandom_range(48, 1), 1);
    end
    stall_pct = 0; dly_max = 0; tx_mode = 0;

    // Reset in the middle of a long packet.
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(ram[8'(i / 4)][8 * (i % 4) +: 8]);
    wr(8'h04, 32'h0); wr(8'h08, 32'd256);
    tx_cnt = 0; exp_addr = 0;
    wr(8'h00, 32'h1);
    for (int k = 0; k < 2000 && tx_cnt < 6; k++) @(posedge clk_i);
    #4 rst_ni = 0;
    #1;
    chk("mid_rst_outs", {19'd0, ack_o, mem_cyc_o, mem_stb_o, mem_we_o, utmi_txvalid_o, utmi_data_o}, 32'd0);
    chk("mid_rst_maddr", mem_addr_o, 32'd0);
    chk("mid_rst_rdata", data_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    rd(8'h0C, r); chk("post_rst_status", r, 32'd0);
    rd(8'h08, r); chk("post_rst_len", r, 32'd0);
    run(32'h100, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
